exec_checkpoint_monitor: RTL and testbench

Synthesizable, parametrised execution monitor that sits beside the processor core and watches its PC and register-file write port. It steps through a programmable, ordered table of checkpoints (PC address, register or write-data source, expected value, mask). It reports pass, fail (with failing index) or timeout with a saturating cycle count. It replaces ad-hoc per-program bench checks with one reusable block that works in simulation and on an FPGA.

---
 rtl/exec_checkpoint_monitor.sv | 175 +++++++++++++++++
 tb/tb_exec_checkpoint_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_checkpoint_monitor.sv
// Execution checkpoint monitor: tracks the core PC and register-file write port against an ordered table of checkpoints.
// Latency: a trigger in cycle k updates state at the edge that ends cycle k, so done/pass are visible in cycle k+1.
// Backpressure: none. The block only observes the core and never stalls it. Table writes are dropped while a run is active.
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset that clears state, shadow registers and table
//   start               one-cycle pulse; starts a run from IDLE or any terminal state
//   PC, RegWrite, WA3,  observed core program counter and register-file write port
//   WD3
//   cfg_*               checkpoint table write port (cfg_we strobe, cfg_idx entry, pc/reg/src/val/mask/final fields)
//   done, pass, timeout run status: done covers pass, fail and timeout
//   fail_idx            index of the mismatching check, or of the check still pending at timeout
//   check_ptr           index of the checkpoint currently armed
//   cycle_count         cycles spent in RUN, saturating at 16'hFFFF
module exec_checkpoint_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CHECKS = 4,
  parameter int NREGS      = 15,
  parameter int MAX_CYCLES = 1024,
  parameter int IDX_W      = $clog2(NUM_CHECKS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] PC,
  input  logic                  RegWrite,
  input  logic [3:0]            WA3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [DATA_WIDTH-1:0] cfg_pc,
  input  logic [3:0]            cfg_reg,
  input  logic                  cfg_src,
  input  logic [DATA_WIDTH-1:0] cfg_val,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic                  cfg_final,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [IDX_W-1:0]      fail_idx,
  output logic [IDX_W-1:0]      check_ptr,
  output logic [15:0]           cycle_count
);

  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} stateT;

  localparam logic [15:0]      LAST_CYCLE   = 16'(MAX_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W:0]   NUM_CHECKS_W = (IDX_W + 1)'(NUM_CHECKS);
  localparam logic [4:0]       NREGS_W      = 5'(NREGS);

  stateT state, nextState;
  logic [IDX_W-1:0] nextPtr;
  logic [IDX_W-1:0] nextFailIdx;
  logic [15:0]      nextCount;

  // Checkpoint table. Only the valid bits need a reset, because an entry is never used until it has been written.
  logic [DATA_WIDTH-1:0] tabPc   [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] tabVal  [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] tabMask [NUM_CHECKS];
  logic [3:0]            tabReg  [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] tabSrc;
  logic [NUM_CHECKS-1:0] tabFinal;
  logic [NUM_CHECKS-1:0] tabValid;

  logic [DATA_WIDTH-1:0] shadow [NREGS];

  logic cfgAccept;
  assign cfgAccept = cfg_we && (state != RUN) && ({1'b0, cfg_idx} < NUM_CHECKS_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tabValid <= '0;
    end else if (cfgAccept) begin
      tabValid[cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfgAccept) begin
      tabPc[cfg_idx]    <= cfg_pc;
      tabVal[cfg_idx]   <= cfg_val;
      tabMask[cfg_idx]  <= cfg_mask;
      tabReg[cfg_idx]   <= cfg_reg;
      tabSrc[cfg_idx]   <= cfg_src;
      tabFinal[cfg_idx] <= cfg_final;
    end
  end

  // The shadow copy of the core register file tracks writes in every state, so values written before a run starts are still visible to checks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= '0;
      end
    end else if (RegWrite && ({1'b0, WA3} < NREGS_W)) begin
      shadow[WA3] <= WD3;
    end
  end

  // Evaluate the armed entry. Reading the shadow array here returns the value held before this cycle's write, because the write lands at the coming edge.
  logic [3:0]            regSel;
  logic [DATA_WIDTH-1:0] shadowRd;
  logic [DATA_WIDTH-1:0] observed;
  logic                  entValid;
  logic                  trigger;
  logic                  entMatch;

  assign regSel   = tabReg[check_ptr];
  assign shadowRd = ({1'b0, regSel} < NREGS_W) ? shadow[regSel] : '0;
  assign observed = tabSrc[check_ptr] ? WD3 : shadowRd;
  assign entValid = tabValid[check_ptr];
  assign trigger  = entValid && (PC == tabPc[check_ptr]);
  // A write-data check compares nothing unless the core is actually writing, so a missing write counts as a mismatch.
  assign entMatch = (((observed ^ tabVal[check_ptr]) & tabMask[check_ptr]) == '0) &&
                    (!tabSrc[check_ptr] || RegWrite);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      check_ptr   <= '0;
      fail_idx    <= '0;
      cycle_count <= '0;
    end else begin
      state       <= nextState;
      check_ptr   <= nextPtr;
      fail_idx    <= nextFailIdx;
      cycle_count <= nextCount;
    end
  end

  always_comb begin
    nextState   = state;
    nextPtr     = check_ptr;
    nextFailIdx = fail_idx;
    nextCount   = cycle_count;
    case (state)
      RUN: begin
        if (cycle_count != 16'hFFFF) begin
          nextCount = cycle_count + 16'd1;
        end
        // A trigger outranks budget expiry in the same cycle. An unprogrammed entry means every configured check has already passed.
        if (!entValid) begin
          nextState = PASS;
        end else if (trigger) begin
          if (entMatch) begin
            if (tabFinal[check_ptr] || (check_ptr == LAST_IDX)) begin
              nextState = PASS;
            end else begin
              nextPtr = check_ptr + IDX_W'(1);
            end
          end else begin
            nextState   = FAIL;
            nextFailIdx = check_ptr;
          end
        end else if (cycle_count == LAST_CYCLE) begin
          nextState   = TIMEOUT;
          nextFailIdx = check_ptr;
        end
      end
      default: begin
        if (start) begin
          nextState   = RUN;
          nextPtr     = '0;
          nextFailIdx = '0;
          nextCount   = '0;
        end
      end
    endcase
  end

  assign done    = (state == PASS) || (state == FAIL) || (state == TIMEOUT);
  assign pass    = (state == PASS);
  assign timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_exec_checkpoint_monitor.sv
// Directed bench for exec_checkpoint_monitor (MAX_CYCLES=16, NUM_CHECKS=4, NREGS=15).
// Table rows drive one cycle of inputs each and hold the expected outputs after the edge that ends that cycle.
// Hand-written sequences cover async reset, configuration lockout, the timeout budget and the ordering of simultaneous events.
module tb_exec_checkpoint_monitor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] PC;
  logic        RegWrite;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_pc;
  logic [3:0]  cfg_reg;
  logic        cfg_src;
  logic [31:0] cfg_val;
  logic [31:0] cfg_mask;
  logic        cfg_final;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [1:0]  fail_idx;
  logic [1:0]  check_ptr;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  exec_checkpoint_monitor #(
    .DATA_WIDTH(32),
    .NUM_CHECKS(4),
    .NREGS(15),
    .MAX_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .PC(PC),
    .RegWrite(RegWrite),
    .WA3(WA3),
    .WD3(WD3),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_pc(cfg_pc),
    .cfg_reg(cfg_reg),
    .cfg_src(cfg_src),
    .cfg_val(cfg_val),
    .cfg_mask(cfg_mask),
    .cfg_final(cfg_final),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .fail_idx(fail_idx),
    .check_ptr(check_ptr),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [31:0] pc;
    logic        rw;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        eDone;
    logic        ePass;
    logic        eTo;
    logic [1:0]  eFail;
    logic [1:0]  ePtr;
    logic [15:0] eCnt;
  } rowT;

  rowT rows [19];

  function automatic rowT mk(input logic st, input logic [31:0] pc, input logic rw,
                             input logic [3:0] wa, input logic [31:0] wd,
                             input logic eDone, input logic ePass, input logic eTo,
                             input logic [1:0] eFail, input logic [1:0] ePtr,
                             input logic [15:0] eCnt);
    rowT r;
    r.st = st; r.pc = pc; r.rw = rw; r.wa = wa; r.wd = wd;
    r.eDone = eDone; r.ePass = ePass; r.eTo = eTo;
    r.eFail = eFail; r.ePtr = ePtr; r.eCnt = eCnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] idx, input logic [31:0] pc, input logic [3:0] rg,
                          input logic src, input logic [31:0] val, input logic [31:0] mask,
                          input logic fin);
    cfg_idx = idx; cfg_pc = pc; cfg_reg = rg; cfg_src = src;
    cfg_val = val; cfg_mask = mask; cfg_final = fin;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic checkAll(input string tag, input logic eDone, input logic ePass, input logic eTo,
                          input logic [1:0] eFail, input logic [1:0] ePtr, input logic [15:0] eCnt);
    chk({tag, " done"}, done, eDone);
    chk({tag, " pass"}, pass, ePass);
    chk({tag, " timeout"}, timeout, eTo);
    chk({tag, " fail_idx"}, fail_idx, eFail);
    chk({tag, " check_ptr"}, check_ptr, ePtr);
    chk({tag, " cycle_count"}, cycle_count, eCnt);
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start = rows[i].st; PC = rows[i].pc; RegWrite = rows[i].rw;
      WA3 = rows[i].wa; WD3 = rows[i].wd;
      step();
      start = 1'b0;
      checkAll($sformatf("row%0d", i), rows[i].eDone, rows[i].ePass, rows[i].eTo,
               rows[i].eFail, rows[i].ePtr, rows[i].eCnt);
    end
    RegWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Branch-and-link: shadow r14 is written before the trigger PC.
    rows[0]  = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[1]  = mk(0, 32'h00, 1, 4'd14, 32'h4,  0, 0, 0, 2'd0, 2'd0, 16'd1);
    rows[2]  = mk(0, 32'h10, 0, 4'd0,  32'h0,  1, 1, 0, 2'd0, 2'd0, 16'd2);
    rows[3]  = mk(0, 32'h10, 0, 4'd0,  32'h0,  1, 1, 0, 2'd0, 2'd0, 16'd2);
    // Write-data mode: wrong data fails, correct data passes, no write fails.
    rows[4]  = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[5]  = mk(0, 32'h24, 1, 4'd1,  32'h5,  1, 0, 0, 2'd0, 2'd0, 16'd1);
    rows[6]  = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[7]  = mk(0, 32'h24, 1, 4'd1,  32'h4,  1, 1, 0, 2'd0, 2'd0, 16'd1);
    rows[8]  = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[9]  = mk(0, 32'h24, 0, 4'd1,  32'h4,  1, 0, 0, 2'd0, 2'd0, 16'd1);
    // Ordered checks: an out-of-order PC does not advance, one step per trigger, then pass at the last index.
    rows[10] = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[11] = mk(0, 32'h10, 1, 4'd3,  32'h33, 0, 0, 0, 2'd0, 2'd0, 16'd1);
    rows[12] = mk(0, 32'h08, 1, 4'd0,  32'h11, 0, 0, 0, 2'd0, 2'd1, 16'd2);
    rows[13] = mk(0, 32'h10, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd2, 16'd3);
    rows[14] = mk(0, 32'h18, 1, 4'd3,  32'h5B, 0, 0, 0, 2'd0, 2'd3, 16'd4);
    rows[15] = mk(0, 32'h20, 1, 4'd3,  32'h99, 1, 1, 0, 2'd0, 2'd3, 16'd5);
    // Rerun: r3 now holds 0x99, so check 1 fails with index 1.
    rows[16] = mk(1, 32'h00, 0, 4'd0,  32'h0,  0, 0, 0, 2'd0, 2'd0, 16'd0);
    rows[17] = mk(0, 32'h08, 1, 4'd0,  32'h11, 0, 0, 0, 2'd0, 2'd1, 16'd1);
    rows[18] = mk(0, 32'h10, 0, 4'd0,  32'h0,  1, 0, 0, 2'd1, 2'd1, 16'd2);

    reset = 1'b1; start = 1'b0; PC = '0; RegWrite = 1'b0; WA3 = '0; WD3 = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_pc = '0; cfg_reg = '0; cfg_src = 1'b0;
    cfg_val = '0; cfg_mask = '0; cfg_final = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkAll("reset", 0, 0, 0, 2'd0, 2'd0, 16'd0);

    cfgWrite(2'd0, 32'h10, 4'd14, 1'b0, 32'h4, 32'hFFFF_FFFC, 1'b1);
    runRows(0, 3);

    cfgWrite(2'd0, 32'h24, 4'd0, 1'b1, 32'h4, 32'hFFFF_FFFF, 1'b1);
    runRows(4, 9);

    cfgWrite(2'd0, 32'h08, 4'd0, 1'b1, 32'h11, 32'hFFFF_FFFF, 1'b0);
    cfgWrite(2'd1, 32'h10, 4'd3, 1'b0, 32'h33, 32'hFFFF_FFFF, 1'b0);
    cfgWrite(2'd2, 32'h18, 4'd0, 1'b1, 32'hAB, 32'h0000_000F, 1'b0);
    cfgWrite(2'd3, 32'h20, 4'd3, 1'b0, 32'h5B, 32'hFFFF_FFFF, 1'b0);
    runRows(10, 18);

    // Async reset mid-run: outputs clear without waiting for an edge, and the table is emptied.
    start = 1'b1; step(); start = 1'b0;
    PC = 32'h08; RegWrite = 1'b1; WA3 = 4'd0; WD3 = 32'h11;
    step();
    RegWrite = 1'b0; PC = '0;
    chk("prereset check_ptr", check_ptr, 2'd1);
    #2 reset = 1'b1;
    #1;
    checkAll("async reset", 0, 0, 0, 2'd0, 2'd0, 16'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    checkAll("empty table", 1, 1, 0, 2'd0, 2'd0, 16'd1);

    // Only entry 0 is programmed and it is non-final. It reads r3, which the reset must have cleared.
    // A table write attempted during the run must be ignored, leaving entry 1 invalid.
    cfgWrite(2'd0, 32'h40, 4'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    PC = 32'h40;
    cfg_idx = 2'd1; cfg_pc = 32'h50; cfg_reg = 4'd0; cfg_src = 1'b1;
    cfg_val = 32'h0; cfg_mask = 32'h0; cfg_final = 1'b1; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0; PC = '0;
    checkAll("lockout step", 0, 0, 0, 2'd0, 2'd1, 16'd1);
    step();
    checkAll("invalid entry", 1, 1, 0, 2'd0, 2'd1, 16'd2);

    // Timeout: the trigger PC never appears. A start pulse mid-run must not restart the count.
    cfgWrite(2'd0, 32'h100, 4'd0, 1'b1, 32'h9, 32'hFFFF_FFFF, 1'b1);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      start = (i == 5);
      step();
      start = 1'b0;
      if (i == 15) checkAll("pre-expiry", 0, 0, 0, 2'd0, 2'd0, 16'd15);
      if (i == 16) checkAll("timeout", 1, 0, 1, 2'd0, 2'd0, 16'd16);
    end
    repeat (2) step();
    checkAll("timeout held", 1, 0, 1, 2'd0, 2'd0, 16'd16);

    // start together with a table write: the run must use the new value 7 rather than 9.
    // The trigger then arrives in the cycle where the budget expires, and the trigger result must win.
    cfg_idx = 2'd0; cfg_pc = 32'h100; cfg_reg = 4'd0; cfg_src = 1'b1;
    cfg_val = 32'h7; cfg_mask = 32'hFFFF_FFFF; cfg_final = 1'b1;
    cfg_we = 1'b1; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    checkAll("start+cfg", 0, 0, 0, 2'd0, 2'd0, 16'd0);
    for (int i = 1; i <= 15; i++) step();
    PC = 32'h100; RegWrite = 1'b1; WA3 = 4'd0; WD3 = 32'h7;
    step();
    RegWrite = 1'b0; PC = '0;
    checkAll("trigger at expiry", 1, 1, 0, 2'd0, 2'd0, 16'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
